// File: rtl/parking_pkg.sv
// Shared types for the multi-lane parking garage LIFO: command opcodes and response status flags.
package parking_pkg;

    typedef enum logic [1:0] {
        OpPush   = 2'd0,
        OpPop    = 2'd1,
        OpPeek   = 2'd2,
        OpSearch = 2'd3
    } op_e;

    // Width-independent part of a response; data/index widths follow the top-level parameters.
    typedef struct packed {
        logic hit;
        logic multi;
        logic error;
    } rsp_flags_t;

endpackage

// File: rtl/parking_lane.sv
// One LIFO lane: slot memory, fill pointer, post-PUSH/POP cooldown counter and a search encoder.
module parking_lane #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned COOLDOWN_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic [DATA_WIDTH-1:0]      key,
    output logic [DATA_WIDTH-1:0]      top_data,
    output logic [$clog2(DEPTH):0]     ptr,
    output logic                       full,
    output logic                       empty,
    output logic                       cooldown,
    output logic                       hit,
    output logic                       multi,
    output logic [$clog2(DEPTH)-1:0]   match_index,
    output logic [DATA_WIDTH-1:0]      match_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam logic [IDX_W:0]   PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W:0]        ptr_q, ptr_d;
    logic [IDX_W:0]        top_ptr;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign top_ptr  = ptr_q - PTR_ONE;
    assign top_data = mem[top_ptr[IDX_W-1:0]];
    assign ptr      = ptr_q;
    assign full     = (ptr_q == IDX_W'(0) + (IDX_W + 1)'(DEPTH));
    assign empty    = (ptr_q == '0);
    assign cooldown = (cnt_q != '0);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
        if (push) begin
            ptr_d = ptr_q + PTR_ONE;
            cnt_d = CNT_W'(COOLDOWN_CYCLES);
        end else if (pop) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = CNT_W'(COOLDOWN_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately left uncleared by reset; only the pointer defines live slots.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_q[IDX_W-1:0]] <= push_data;
        end
    end

    // Ascending scan so the highest live matching slot wins; a second match flags multi.
    always_comb begin
        hit         = 1'b0;
        multi       = 1'b0;
        match_index = '0;
        match_data  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((IDX_W + 1)'(i) < ptr_q) && (mem[i] == key)) begin
                if (hit) begin
                    multi = 1'b1;
                end
                hit         = 1'b1;
                match_index = IDX_W'(i);
                match_data  = mem[i];
            end
        end
    end

endmodule

// File: rtl/parking_garage_lifo.sv
// Multi-lane valet LIFO: decodes one command per cycle, steers it to a lane, registers the response.
module parking_garage_lifo
    import parking_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned NUM_LANES       = 4,
    parameter int unsigned COOLDOWN_CYCLES = 1,
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [LANE_W-1:0]     cmd_lane,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,
    output logic                  rsp_multi,
    output logic [IDX_W-1:0]      rsp_index,
    output logic                  rsp_error,
    output logic [NUM_LANES-1:0]  lane_full,
    output logic [NUM_LANES-1:0]  lane_empty,
    output logic [NUM_LANES-1:0]  lane_cooldown
);

    // Lane arrays are padded to the full index range so cmd_lane always selects a real element.
    localparam int unsigned NUM_SLOTS = 1 << LANE_W;
    localparam logic [IDX_W:0] PTR_ONE = 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        rsp_flags_t            flags;
        logic [IDX_W-1:0]      index;
    } rsp_t;

    op_e                   op;
    logic                  lane_ok;
    logic                  is_push_pop;
    logic                  accept;
    logic [IDX_W:0]        sel_top_ptr;

    logic [DATA_WIDTH-1:0] top_data    [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] match_data  [NUM_SLOTS];
    logic [IDX_W:0]        ptr         [NUM_SLOTS];
    logic [IDX_W-1:0]      match_index [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  full, empty, cool, hit, multi, push, pop;

    rsp_t                  rsp_d, rsp_q;
    logic                  rsp_valid_d, rsp_valid_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_lane
        if (g < NUM_LANES) begin : g_real
            parking_lane #(
                .DATA_WIDTH      (DATA_WIDTH),
                .DEPTH           (DEPTH),
                .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .push        (push[g]),
                .pop         (pop[g]),
                .push_data   (cmd_data),
                .key         (cmd_data),
                .top_data    (top_data[g]),
                .ptr         (ptr[g]),
                .full        (full[g]),
                .empty       (empty[g]),
                .cooldown    (cool[g]),
                .hit         (hit[g]),
                .multi       (multi[g]),
                .match_index (match_index[g]),
                .match_data  (match_data[g])
            );
        end else begin : g_pad
            assign top_data[g]    = '0;
            assign match_data[g]  = '0;
            assign ptr[g]         = '0;
            assign match_index[g] = '0;
            assign full[g]        = 1'b0;
            assign empty[g]       = 1'b1;
            assign cool[g]        = 1'b0;
            assign hit[g]         = 1'b0;
            assign multi[g]       = 1'b0;
        end
    end

    assign op          = op_e'(cmd_op);
    assign lane_ok     = (32'(cmd_lane) < NUM_LANES);
    assign is_push_pop = (op == OpPush) || (op == OpPop);
    assign cmd_ready   = !(is_push_pop && lane_ok && cool[cmd_lane]);
    // A command in a reset cycle is dropped: no lane update and no response.
    assign accept      = cmd_valid && cmd_ready && reset;
    assign sel_top_ptr = ptr[cmd_lane] - PTR_ONE;

    always_comb begin
        push        = '0;
        pop         = '0;
        rsp_d       = '0;
        rsp_valid_d = 1'b0;
        if (accept) begin
            rsp_valid_d = 1'b1;
            if (!lane_ok) begin
                rsp_d.flags.error = 1'b1;
            end else begin
                unique case (op)
                    OpPush: begin
                        if (full[cmd_lane]) begin
                            rsp_d.flags.error = 1'b1;
                        end else begin
                            push[cmd_lane] = 1'b1;
                            rsp_d.index    = ptr[cmd_lane][IDX_W-1:0];
                        end
                    end
                    OpPop, OpPeek: begin
                        if (empty[cmd_lane]) begin
                            rsp_d.flags.error = 1'b1;
                        end else begin
                            pop[cmd_lane] = (op == OpPop);
                            rsp_d.data    = top_data[cmd_lane];
                            rsp_d.index   = sel_top_ptr[IDX_W-1:0];
                        end
                    end
                    OpSearch: begin
                        if (hit[cmd_lane]) begin
                            rsp_d.flags.hit   = 1'b1;
                            rsp_d.flags.multi = multi[cmd_lane];
                            rsp_d.data        = match_data[cmd_lane];
                            rsp_d.index       = match_index[cmd_lane];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_q.data;
    assign rsp_hit       = rsp_q.flags.hit;
    assign rsp_multi     = rsp_q.flags.multi;
    assign rsp_index     = rsp_q.index;
    assign rsp_error     = rsp_q.flags.error;
    assign lane_full     = full[NUM_LANES-1:0];
    assign lane_empty    = empty[NUM_LANES-1:0];
    assign lane_cooldown = cool[NUM_LANES-1:0];

endmodule

// File: tb/tb_parking_garage_lifo.sv
// Bench for parking_garage_lifo: a 4-lane C=3 instance and a 1-lane C=0 instance against a queue model.
module tb_parking_garage_lifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 lanes, cooldown 3
    logic        a_reset = 1'b1, a_valid = 1'b0, a_ready;
    logic [1:0]  a_op = '0, a_lane = '0;
    logic [15:0] a_data = '0, a_rsp_data;
    logic        a_rsp_valid, a_rsp_hit, a_rsp_multi, a_rsp_error;
    logic [2:0]  a_rsp_index;
    logic [3:0]  a_full, a_empty, a_cool;

    // Instance B: 1 lane, no cooldown
    logic        b_reset = 1'b1, b_valid = 1'b0, b_ready;
    logic [1:0]  b_op = '0;
    logic [0:0]  b_lane = '0;
    logic [15:0] b_data = '0, b_rsp_data;
    logic        b_rsp_valid, b_rsp_hit, b_rsp_multi, b_rsp_error;
    logic [2:0]  b_rsp_index;
    logic [0:0]  b_full, b_empty, b_cool;

    parking_garage_lifo #(
        .DATA_WIDTH(16), .DEPTH(8), .NUM_LANES(4), .COOLDOWN_CYCLES(3)
    ) dut_a (
        .clk(clk), .reset(a_reset), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_op(a_op), .cmd_lane(a_lane), .cmd_data(a_data),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_hit(a_rsp_hit),
        .rsp_multi(a_rsp_multi), .rsp_index(a_rsp_index), .rsp_error(a_rsp_error),
        .lane_full(a_full), .lane_empty(a_empty), .lane_cooldown(a_cool)
    );

    parking_garage_lifo #(
        .DATA_WIDTH(16), .DEPTH(8), .NUM_LANES(1), .COOLDOWN_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(b_reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_lane(b_lane), .cmd_data(b_data),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_hit(b_rsp_hit),
        .rsp_multi(b_rsp_multi), .rsp_index(b_rsp_index), .rsp_error(b_rsp_error),
        .lane_full(b_full), .lane_empty(b_empty), .lane_cooldown(b_cool)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-lane queues and cooldown counts; slots 0..3 = A, slot 4 = B.
    logic [15:0] mq  [5][$];
    int          mcd [5];

    localparam logic [1:0] PUSH = 2'd0, POP = 2'd1, PEEK = 2'd2, SEARCH = 2'd3;

    // Expected vector: {ready, valid, error, hit, multi, index[2:0], data[15:0], full, empty, cool}
    task automatic model_step(input int u, input bit rst, input bit v, input logic [1:0] op,
                              input int lane, input logic [15:0] d, output logic [35:0] e);
        int nl = (u != 0) ? 1 : 4;
        int cc = (u != 0) ? 0 : 3;
        int b  = (u != 0) ? 4 : 0;
        int sz, cnt, li;
        bit mready = 1'b1;
        bit rv = 0, re = 0, rh = 0, rm = 0;
        logic [2:0]  ri = '0;
        logic [15:0] rd = '0;
        logic [3:0]  fl = '0, em = '0, co = '0;
        if ((op == PUSH || op == POP) && lane < nl) begin
            if (mcd[b + lane] != 0) mready = 1'b0;
        end
        for (int i = 0; i < nl; i++) if (mcd[b + i] > 0) mcd[b + i]--;
        if (!rst) begin
            for (int i = 0; i < nl; i++) begin
                mq[b + i].delete();
                mcd[b + i] = 0;
            end
        end else if (v && mready) begin
            rv = 1'b1;
            if (lane >= nl) begin
                re = 1'b1;
            end else begin
                li = b + lane;
                sz = mq[li].size();
                case (op)
                    PUSH: if (sz == 8) re = 1'b1;
                          else begin mq[li].push_back(d); ri = 3'(sz); mcd[li] = cc; end
                    POP:  if (sz == 0) re = 1'b1;
                          else begin rd = mq[li].pop_back(); ri = 3'(sz - 1); mcd[li] = cc; end
                    PEEK: if (sz == 0) re = 1'b1;
                          else begin rd = mq[li][sz - 1]; ri = 3'(sz - 1); end
                    default: begin
                        cnt = 0;
                        for (int k = sz - 1; k >= 0; k--) begin
                            if (mq[li][k] == d) begin
                                if (cnt == 0) begin rd = mq[li][k]; ri = 3'(k); end
                                cnt++;
                            end
                        end
                        rh = (cnt > 0);
                        rm = (cnt > 1);
                    end
                endcase
            end
        end
        for (int i = 0; i < nl; i++) begin
            fl[i] = (mq[b + i].size() == 8);
            em[i] = (mq[b + i].size() == 0);
            co[i] = (mcd[b + i] != 0);
        end
        e = {mready, rv, re, rh, rm, ri, rd, fl, em, co};
    endtask

    // Drives one cycle on instance u (the other idles), returns observed and expected vectors.
    task automatic run(input int u, input bit rst, input bit v, input logic [1:0] op,
                       input int lane, input logic [15:0] d,
                       output logic [35:0] obs, output logic [35:0] exp);
        logic [35:0] idle;
        @(negedge clk);
        if (u == 0) begin
            a_reset = rst; a_valid = v; a_op = op; a_lane = lane[1:0]; a_data = d;
            b_reset = 1'b1; b_valid = 1'b0;
        end else begin
            b_reset = rst; b_valid = v; b_op = op; b_lane = lane[0:0]; b_data = d;
            a_reset = 1'b1; a_valid = 1'b0;
        end
        #1;
        obs[35] = (u != 0) ? b_ready : a_ready;
        model_step(u, rst, v, op, lane, d, exp);
        model_step(1 - u, 1'b1, 1'b0, PUSH, 0, 16'h0, idle);
        @(posedge clk);
        #1;
        if (u == 0)
            obs[34:0] = {a_rsp_valid, a_rsp_error, a_rsp_hit, a_rsp_multi, a_rsp_index,
                         a_rsp_data, a_full, a_empty, a_cool};
        else
            obs[34:0] = {b_rsp_valid, b_rsp_error, b_rsp_hit, b_rsp_multi, b_rsp_index,
                         b_rsp_data, 3'b0, b_full, 3'b0, b_empty, 3'b0, b_cool};
        a_valid = 1'b0;
        b_valid = 1'b0;
        n_vec++;
    endtask

    task automatic test_reset();
        logic [35:0] obs, exp;
        for (int k = 0; k < 4; k++) begin
            run(k % 2, (k < 2) ? 1'b0 : 1'b1, 1'b0, PUSH, 0, 16'h0, obs, exp);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_state step %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_push_pop();
        logic [35:0] obs, exp;
        logic [1:0]  ops [3] = '{PUSH, PUSH, POP};
        logic [15:0] dat [3] = '{16'h1111, 16'h2222, 16'h0};
        int stalls = 0;
        for (int k = 0; k < 3; k++) begin
            int tries = 0;
            do begin
                run(0, 1'b1, 1'b1, ops[k], 2, dat[k], obs, exp);
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL push_pop_lane2 cmd %0d try %0d: got %h want %h",
                             k, tries, obs, exp);
                end
                if (k == 1 && !obs[35]) stalls++;
                tries++;
            end while (!exp[35] && tries < 16);
        end
        if (stalls !== 3) begin
            n_err++;
            $display("FAIL push_cooldown_stalls: got %0d want 3", stalls);
        end
    endtask

    task automatic test_full_errors();
        logic [35:0] obs, exp;
        for (int k = 0; k < 10; k++) begin
            int tries = 0;
            do begin
                run(0, 1'b1, 1'b1, (k < 9) ? PUSH : POP, (k < 9) ? 0 : 1,
                    16'($urandom), obs, exp);
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL full_and_empty cmd %0d: got %h want %h", k, obs, exp);
                end
                tries++;
            end while (!exp[35] && tries < 16);
        end
    endtask

    task automatic test_search();
        logic [35:0] obs, exp;
        logic [1:0]  ops [7] = '{PUSH, PUSH, PUSH, SEARCH, SEARCH, SEARCH, PEEK};
        logic [15:0] dat [7] = '{16'hA, 16'hB, 16'hA, 16'hA, 16'hC, 16'hB, 16'h0};
        for (int k = 0; k < 7; k++) begin
            int tries = 0;
            do begin
                run(0, 1'b1, 1'b1, ops[k], 3, dat[k], obs, exp);
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL search_lane3 cmd %0d: got %h want %h", k, obs, exp);
                end
                tries++;
            end while (!exp[35] && tries < 16);
        end
    endtask

    task automatic test_cooldown_lanes();
        logic [35:0] obs, exp;
        logic [1:0]  ops [4] = '{POP, PUSH, PEEK, PUSH};
        int          ln  [4] = '{0, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            int tries = 0;
            do begin
                run(0, 1'b1, 1'b1, ops[k], ln[k], 16'h5A5A + 16'(k), obs, exp);
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL cooldown_lanes cmd %0d: got %h want %h", k, obs, exp);
                end
                tries++;
            end while (!exp[35] && tries < 16);
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] obs, exp;
        for (int k = 0; k < 2; k++) begin
            run(0, (k == 0) ? 1'b0 : 1'b1, 1'b1, (k == 0) ? PUSH : PEEK, 1, 16'h7777, obs, exp);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid step %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] obs, exp;
        for (int k = 0; k < 600; k++) begin
            bit         rst = ($urandom_range(0, 149) != 0);
            bit         v   = ($urandom_range(0, 3) != 0);
            logic [1:0] op  = ($urandom_range(0, 9) < 4) ? PUSH : 2'($urandom_range(1, 3));
            run(0, rst, v, op, $urandom_range(0, 3), 16'($urandom_range(10, 13)), obs, exp);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random_a cycle %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] obs, exp;
        for (int k = 0; k < 20; k++) begin
            run(1, (k == 0) ? 1'b0 : 1'b1, 1'b1, (k < 10) ? PUSH : POP, 0,
                16'h0100 + 16'(k), obs, exp);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back step %0d: got %h want %h", k, obs, exp);
            end
        end
        for (int k = 0; k < 300; k++) begin
            run(1, 1'b1, ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0) ? 1 : 0, 16'($urandom_range(1, 4)), obs, exp);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random_b cycle %0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) mcd[i] = 0;
        @(negedge clk);
        a_reset = 1'b0;
        b_reset = 1'b0;
        repeat (2) @(negedge clk);
        a_reset = 1'b1;
        b_reset = 1'b1;
        test_reset();
        test_push_pop();
        test_full_errors();
        test_search();
        test_cooldown_lanes();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
